// File: rtl/picomips_pkg.sv
// Shared types and default sizing for the picoMIPS sequencer.
package picomips_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 5;
    localparam int unsigned MUL_LAT_DEFAULT  = 2;

    typedef enum logic [2:0] {
        RUN,
        LOAD_ARM,
        LOAD_WAIT,
        LOAD_REL,
        MUL_WAIT,
        HALT
    } seq_state_t;

endpackage

// File: rtl/opcodes.sv
// picoMIPS 3-bit opcode encodings shared by the decoder, the sequencer and the benches.
`ifndef OPCODES_SV
`define OPCODES_SV

`define OP_NOP  3'b000
`define OP_ADD  3'b001
`define OP_ADDI 3'b010
`define OP_MULI 3'b011
`define OP_LOAD 3'b100

`endif

// File: rtl/picomips_sequencer.sv
// Multi-cycle sequencer: owns the PC and gates register-file writes for LOAD, MULI and NOP.
`include "opcodes.sv"

module picomips_sequencer
    import picomips_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEFAULT,
    parameter int unsigned MUL_LAT  = MUL_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [2:0]          opcode,
    input  logic                dec_pcincr,
    input  logic                dec_write,
    input  logic                btn,
    output logic [PC_WIDTH-1:0] pc,
    output logic                reg_we,
    output logic                stall,
    output logic                halted
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    seq_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                halted_q, halted_d;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q  <= RUN;
            pc_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        reg_we   = 1'b0;
        stall    = 1'b0;

        case (state_q)
            RUN: begin
                case (opcode)
                    `OP_ADD, `OP_ADDI: begin
                        reg_we = dec_write;
                        pc_d   = pc_q + PC_WIDTH'(dec_pcincr);
                    end
                    `OP_MULI: begin
                        if (MUL_LAT == 0) begin
                            reg_we = dec_write;
                            pc_d   = pc_q + PC_WIDTH'(dec_pcincr);
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                            state_d = MUL_WAIT;
                        end
                    end
                    `OP_LOAD: begin
                        stall   = 1'b1;
                        state_d = LOAD_ARM;
                    end
                    default: begin
                        stall    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
                endcase
            end

            // A press still held from a previous LOAD must be released before arming.
            LOAD_ARM: begin
                stall = 1'b1;
                if (!btn) begin
                    state_d = LOAD_WAIT;
                end
            end

            LOAD_WAIT: begin
                stall = 1'b1;
                if (btn) begin
                    reg_we  = 1'b1;
                    state_d = LOAD_REL;
                end
            end

            LOAD_REL: begin
                if (!btn) begin
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = RUN;
                end else begin
                    stall = 1'b1;
                end
            end

            MUL_WAIT: begin
                if (cnt_q == '0) begin
                    reg_we  = dec_write;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = RUN;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            HALT: begin
                stall = 1'b1;
            end

            default: begin
                state_d = RUN;
            end
        endcase

        // The reset cycle must never write, even if the FSM was about to retire.
        if (!nReset) begin
            reg_we = 1'b0;
            stall  = 1'b0;
        end
    end

    assign pc     = pc_q;
    assign halted = halted_q;

endmodule
